picosoc_bus_arbiter: RTL and testbench
======================================

PICOSOC_BUS_ARBITER -- requirements
Module: picosoc_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the number of slave-stall cycles before a transfer is force-completed (legal range 1..65535).
REQ-002 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Ports m0_valid, m1_valid  input  1  master request, held high until the matching ready.
REQ-005 Ports m0_ready, m1_ready  output  1  transfer-complete strobe to the master.
REQ-006 Ports m0_addr, m1_addr  input  32  byte address.
REQ-007 Ports m0_wdata, m1_wdata  input  32  write data.
REQ-008 Ports m0_wstrb, m1_wstrb  input  4  byte write strobes; all zero means a read.
REQ-009 Ports m0_rdata, m1_rdata  output  32  read data, valid only while the matching ready is high.
REQ-010 Ports s_valid, s_addr, s_wdata, s_wstrb  output  1/32/32/4  forwarded request to the shared memory bus.
REQ-011 Ports s_ready, s_rdata  input  1/32  shared-bus completion and read data.
REQ-012 Port grant  output  2  one-hot owner: bit0 is m0, bit1 is m1, 00 means idle.
REQ-013 Port timeout_flag  output  1  sticky flag, set when a transfer times out.
REQ-014 Port timeout_clr  input  1  clears timeout_flag.

Function
REQ-015 The FSM SHALL have two states, IDLE and BUSY.
REQ-016 In IDLE with at least one mV valid, the arbiter SHALL register the winner into grant and enter BUSY on the next edge.
REQ-017 Arbitration SHALL be round-robin: on a tie, the master not granted last wins; a single requester always wins.
REQ-018 In BUSY, s_valid, s_addr, s_wdata and s_wstrb SHALL combinationally mirror the granted master; in IDLE, s_valid SHALL be 0.
REQ-019 m<g>_ready SHALL equal s_valid AND s_ready in the same cycle, and m<g>_rdata SHALL equal s_rdata.
REQ-020 The non-granted master's ready SHALL stay 0, and its rdata SHALL be 0.
REQ-021 On the s_ready handshake, the FSM SHALL return to IDLE on the next edge, clear grant, and record last_grant.
REQ-022 An IDLE cycle SHALL separate every pair of consecutive transfers, so the minimum issue-to-ready latency is 1 cycle after the grant edge.
REQ-023 In BUSY, a 16-bit stall counter SHALL increment on each cycle with s_ready low, and SHALL clear on entering BUSY.
REQ-024 When the counter equals TIMEOUT_CYCLES and s_ready is low:
  - the arbiter SHALL drive s_valid=0 that cycle;
  - it SHALL pulse m<g>_ready=1 with m<g>_rdata=0;
  - it SHALL set timeout_flag and go to IDLE.
REQ-025 If s_ready and the timeout coincide, the real completion (s_rdata) SHALL take precedence and timeout_flag SHALL NOT be set.
REQ-026 If the granted master drops valid in BUSY (protocol violation), the FSM SHALL return to IDLE next edge with no ready pulse and last_grant unchanged.
REQ-027 timeout_clr SHALL clear timeout_flag next edge; a simultaneous timeout set SHALL win.
REQ-028 The counter SHALL saturate and never wrap.

Reset
REQ-029 Reset SHALL force:
  - state IDLE;
  - grant=00;
  - s_valid=0 and both readies 0 from the next cycle;
  - counter 0;
  - timeout_flag 0;
  - last_grant=m1 (so m0 wins the first tie).
REQ-030 Reset asserted mid-transfer SHALL abandon the transfer without any ready pulse.

Structure
REQ-031 Package picosoc_bus_pkg SHALL hold the state enum, the grant encodings and the counter width constant.
REQ-032 A combinational sub-module picosoc_rr_pick SHALL compute the winner from (m0_valid, m1_valid, last_grant); all state SHALL stay in the top module.

Verification
REQ-033 Only m0 reads 0x0000_0100, s_ready follows 2 cycles after s_valid, s_rdata=0x1234_5678 -> m0_ready pulses once with m0_rdata=0x1234_5678 and grant goes 01 then 00.
REQ-034 Both masters request continuously after reset, each s_ready immediate -> grants run 01,00,10,00,01,... with m0 first.
REQ-035 m1 writes wstrb=0011, data=0xAABB_CCDD, at 0x0200_0004 -> s_wstrb=0011 and s_wdata=0xAABB_CCDD while BUSY; m0_ready stays 0.
REQ-036 TIMEOUT_CYCLES=4, s_ready held 0 -> m<g>_ready pulses with rdata 0 on the 5th BUSY cycle and timeout_flag=1; timeout_clr then clears it next edge.
REQ-037 Reset pulsed during BUSY -> next cycle has grant=00, s_valid=0 and no ready pulse; a following tie is granted to m0.

Source files
------------

// File: rtl/picosoc_bus_pkg.sv
// ============================================================================
// Module : picosoc_bus_pkg
// Brief  : Shared types and constants for the two-master PicoSoC bus arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package picosoc_bus_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  localparam int unsigned      CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // The stall counter holds at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/picosoc_rr_pick.sv
// ============================================================================
// Module : picosoc_rr_pick
// Brief  : Combinational round-robin winner select between two masters.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module picosoc_rr_pick
  import picosoc_bus_pkg::*;
(
  input  logic       m0_valid,
  input  logic       m1_valid,
  input  logic [1:0] last_grant,
  output logic [1:0] winner
);

  always_comb begin
    winner = GRANT_NONE;
    if (m0_valid && m1_valid) begin
      // On a tie the master that did not own the bus last time goes first.
      winner = (last_grant == GRANT_M0) ? GRANT_M1 : GRANT_M0;
    end else if (m0_valid) begin
      winner = GRANT_M0;
    end else if (m1_valid) begin
      winner = GRANT_M1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/picosoc_bus_arbiter.sv
// ============================================================================
// Module : picosoc_bus_arbiter
// Brief  : Two-master round-robin arbiter onto a shared memory bus, with stall timeout.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module picosoc_bus_arbiter
  import picosoc_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,

  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,

  output logic [1:0]  grant,
  output logic        timeout_flag,
  input  logic        timeout_clr
);

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  state_t           r_state;
  logic [1:0]       r_grant;
  logic [1:0]       r_last_grant;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_timeout_flag;

  logic [1:0]       w_winner;
  logic             w_busy;
  logic             w_sel_m1;
  logic             w_sel_valid;
  logic             w_timeout_hit;
  logic             w_handshake;
  logic             w_done;

  picosoc_rr_pick u_rr_pick (
    .m0_valid   (m0_valid),
    .m1_valid   (m1_valid),
    .last_grant (r_last_grant),
    .winner     (w_winner)
  );

  // Reset gates the bus immediately so an abandoned transfer never completes.
  assign w_busy      = (r_state == ST_BUSY) && !reset;
  assign w_sel_m1    = r_grant[1];
  assign w_sel_valid = w_sel_m1 ? m1_valid : m0_valid;

  // A real completion in the limit cycle beats the timeout.
  assign w_timeout_hit = w_busy && w_sel_valid && !s_ready && (r_stall_cnt == TIMEOUT_VAL);

  assign s_valid = w_busy && w_sel_valid && !w_timeout_hit;
  assign s_addr  = w_busy ? (w_sel_m1 ? m1_addr  : m0_addr)  : 32'h0;
  assign s_wdata = w_busy ? (w_sel_m1 ? m1_wdata : m0_wdata) : 32'h0;
  assign s_wstrb = w_busy ? (w_sel_m1 ? m1_wstrb : m0_wstrb) : 4'h0;

  assign w_handshake = s_valid && s_ready;
  assign w_done      = w_handshake || w_timeout_hit;

  assign m0_ready = w_done && r_grant[0];
  assign m1_ready = w_done && r_grant[1];
  assign m0_rdata = (w_handshake && r_grant[0]) ? s_rdata : 32'h0;
  assign m1_rdata = (w_handshake && r_grant[1]) ? s_rdata : 32'h0;

  assign grant        = r_grant;
  assign timeout_flag = r_timeout_flag;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_grant        <= GRANT_NONE;
      r_last_grant   <= GRANT_M1;
      r_stall_cnt    <= '0;
      r_timeout_flag <= 1'b0;
    end else begin
      if (w_timeout_hit) begin
        r_timeout_flag <= 1'b1;
      end else if (timeout_clr) begin
        r_timeout_flag <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_winner != GRANT_NONE) begin
            r_state     <= ST_BUSY;
            r_grant     <= w_winner;
            r_stall_cnt <= '0;
          end
        end
        ST_BUSY: begin
          if (!w_sel_valid) begin
            // Master withdrew mid-transfer: drop it without crediting a turn.
            r_state <= ST_IDLE;
            r_grant <= GRANT_NONE;
          end else if (w_done) begin
            r_state      <= ST_IDLE;
            r_grant      <= GRANT_NONE;
            r_last_grant <= r_grant;
          end else begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= GRANT_NONE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_picosoc_bus_arbiter.sv
// ============================================================================
// Module : tb_picosoc_bus_arbiter
// Brief  : Scoreboard bench for picosoc_bus_arbiter (TIMEOUT_CYCLES = 4).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_picosoc_bus_arbiter;

  typedef struct packed {
    logic        who;
    logic [31:0] rdata;
  } exp_t;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
  logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic [1:0]  grant;
  logic        timeout_flag;
  logic        timeout_clr = 1'b0;

  logic        slave_en    = 1'b0;
  int          slave_delay = 0;
  logic [31:0] slave_data  = '0;
  int          scnt        = 0;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  logic [1:0] rr_seq [8] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};

  picosoc_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .timeout_flag(timeout_flag), .timeout_clr(timeout_clr)
  );

  always #5 clk = ~clk;

  // Slave answers slave_delay cycles into each granted transfer.
  always @(posedge clk) scnt <= ((grant != 2'b00) && !s_ready) ? scnt + 1 : 0;
  assign s_ready = slave_en && (grant != 2'b00) && (scnt == slave_delay);
  assign s_rdata = slave_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  task automatic expect_done(input bit who, input logic [31:0] rdata);
    exp_t e;
    e.who   = who;
    e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  // Monitor: every ready pulse must match the oldest expected completion.
  always @(negedge clk) begin
    exp_t e;
    if (m0_ready === 1'b1 || m1_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ready: actual m0=%b m1=%b required no pulse", m0_ready, m1_ready);
      end else begin
        e = exp_q.pop_front();
        check("ready_m0", 32'(m0_ready), 32'(!e.who));
        check("ready_m1", 32'(m1_ready), 32'(e.who));
        check("rdata", e.who ? m1_rdata : m0_rdata, e.rdata);
        check("rdata_other", e.who ? m0_rdata : m1_rdata, 32'h0);
      end
    end
  end

  task automatic do_xfer(input bit who, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [31:0] exp_rdata,
                         input int exp_cycles, input bit exp_to);
    int cyc;
    bit got;
    expect_done(who, exp_rdata);
    if (who) begin
      m1_valid = 1'b1; m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb;
    end else begin
      m0_valid = 1'b1; m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb;
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("grant_busy", 32'(grant), who ? 32'h2 : 32'h1);
    check("s_valid_busy", 32'(s_valid), 32'h1);
    check("s_addr", s_addr, addr);
    check("s_wdata", s_wdata, wdata);
    check("s_wstrb", 32'(s_wstrb), 32'(wstrb));
    cyc = 1;
    got = who ? m1_ready : m0_ready;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      got = who ? m1_ready : m0_ready;
    end
    check("busy_cycles", cyc, exp_cycles);
    check("s_valid_at_done", 32'(s_valid), exp_to ? 32'h0 : 32'h1);
    @(posedge clk); #1;
    if (who) m1_valid = 1'b0; else m0_valid = 1'b0;
    timeout_clr = 1'b0;
    @(negedge clk);
    check("grant_idle", 32'(grant), 32'h0);
    check("timeout_flag", 32'(timeout_flag), 32'(exp_to));
  endtask

  task automatic run_both(input logic [1:0] first_grant);
    bit done0, done1, r0, r1;
    int guard;
    done0 = 1'b0; done1 = 1'b0; guard = 0;
    m0_valid = 1'b1;
    m1_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("tie_grant", 32'(grant), 32'(first_grant));
    while (!(done0 && done1) && guard < 20) begin
      r0 = m0_ready;
      r1 = m1_ready;
      @(posedge clk); #1;
      if (r0) begin m0_valid = 1'b0; done0 = 1'b1; end
      if (r1) begin m1_valid = 1'b0; done1 = 1'b1; end
      @(negedge clk);
      guard++;
    end
    check("tie_both_done", 32'(done0 && done1), 32'h1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_s_valid", 32'(s_valid), 32'h0);
    check("rst_m0_ready", 32'(m0_ready), 32'h0);
    check("rst_m1_ready", 32'(m1_ready), 32'h0);
    check("rst_timeout_flag", 32'(timeout_flag), 32'h0);

    // Continuous tie with an immediate slave: strict alternation, m0 first.
    slave_en = 1'b1; slave_delay = 0; slave_data = 32'hC0DE_0001;
    expect_done(1'b0, 32'hC0DE_0001);
    expect_done(1'b1, 32'hC0DE_0001);
    expect_done(1'b0, 32'hC0DE_0001);
    expect_done(1'b1, 32'hC0DE_0001);
    m0_valid = 1'b1;
    m1_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rr_grant", 32'(grant), 32'(rr_seq[i]));
      if (i == 7) begin
        m0_valid = 1'b0;
        m1_valid = 1'b0;
      end
    end

    // m0 read, slave answers two cycles after s_valid.
    slave_delay = 2; slave_data = 32'h1234_5678;
    do_xfer(1'b0, 32'h0000_0100, 32'h0, 4'b0000, 32'h1234_5678, 3, 1'b0);

    // m1 partial write.
    slave_delay = 1; slave_data = 32'h0BAD_F00D;
    do_xfer(1'b1, 32'h0200_0004, 32'hAABB_CCDD, 4'b0011, 32'h0BAD_F00D, 2, 1'b0);

    // Stalled slave: timeout on the 5th busy cycle; clear held high loses to set.
    slave_en = 1'b0; slave_data = 32'hFFFF_FFFF; timeout_clr = 1'b1;
    do_xfer(1'b0, 32'h0000_0300, 32'h0, 4'b0000, 32'h0, 5, 1'b1);
    @(negedge clk);
    check("flag_sticky", 32'(timeout_flag), 32'h1);
    @(posedge clk); #1 timeout_clr = 1'b1;
    @(posedge clk); #1 timeout_clr = 1'b0;
    @(negedge clk);
    check("flag_cleared", 32'(timeout_flag), 32'h0);

    // Completion lands exactly in the timeout cycle: real data wins, no flag.
    slave_en = 1'b1; slave_delay = 4; slave_data = 32'h5A5A_0001;
    do_xfer(1'b0, 32'h0000_0400, 32'h0, 4'b0000, 32'h5A5A_0001, 5, 1'b0);

    // m1 withdraws mid-transfer: no ready, and its turn is not credited.
    slave_en = 1'b0;
    m1_addr = 32'h0000_0500; m1_wstrb = 4'b0000; m1_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 m1_valid = 1'b0;
    @(negedge clk);
    check("viol_grant_held", 32'(grant), 32'h2);
    check("viol_s_valid", 32'(s_valid), 32'h0);
    @(negedge clk);
    check("viol_grant_idle", 32'(grant), 32'h0);

    // Last completed owner was m0, so m1 wins the tie.
    slave_en = 1'b1; slave_delay = 0; slave_data = 32'h7777_0001;
    expect_done(1'b1, 32'h7777_0001);
    expect_done(1'b0, 32'h7777_0001);
    run_both(2'b10);

    // Reset during a stalled m1 transfer, then a tie goes to m0.
    slave_en = 1'b0;
    m1_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    m0_valid = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_grant", 32'(grant), 32'h0);
    check("midrst_s_valid", 32'(s_valid), 32'h0);
    check("midrst_m0_ready", 32'(m0_ready), 32'h0);
    check("midrst_m1_ready", 32'(m1_ready), 32'h0);
    slave_en = 1'b1; slave_delay = 0; slave_data = 32'h9999_0001;
    expect_done(1'b0, 32'h9999_0001);
    expect_done(1'b1, 32'h9999_0001);
    run_both(2'b01);

    @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual still running required finished");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
